c66x_power_supervisor: RTL and testbench
========================================

# c66x_power_supervisor

Board-level supervisor that owns the enable input of the C66x power sequencer. Holds the DSP off for a power-on settle period, then follows a board power request. It watches the sequencer state code for failed starts and unexpected drops, and retries with exponential backoff. After a bounded number of retries it latches a fault lockout until software clears it.

## Interface
- TICK_DIV, 500: sysclk cycles per 100 µs tick (≥2).
- STARTUP_TICKS, 100: ticks after reset before any start is allowed (10 ms).
- START_TIMEOUT_TICKS, 2000: ticks allowed for the sequencer to reach `on`.
- BACKOFF_TICKS, 250: base backoff; actual backoff = BACKOFF_TICKS << retry_count.
- RETRY_MAX, 3: failures tolerated before lockout (≤3).
- STABLE_TICKS, 10000: continuous RUNNING ticks that clear retry_count.
- sysclk  in  1  system clock; the only clock.
- sysreset_INV  in  1  asynchronous active-low reset.
- power_request  in  1  board wants DSP powered; level.
- fault_clear  in  1  one-cycle pulse; exits LOCKOUT.
- seq_state  in  4  sequencer state code; asynchronous to decisions, so it is double-flop synchronised.
- seq_enable  out  1  drives sequencer enable.
- dsp_running  out  1  high only in RUNNING.
- fault  out  1  high only in LOCKOUT.
- retry_count  out  2  failures since last stable run.
- sup_state  out  3  current supervisor state.

## Operation
- Sequencer codes: off = 4'h0, on = 4'h9, shutdown = 4'hA–4'hE, startup = 4'h1–4'h8.
- INIT(0): seq_enable=0. After STARTUP_TICKS → IDLE.
- IDLE(1): seq_enable=0.
  - power_request=1 and synced seq_state==off → START.
- START(2): seq_enable=1, timer counts ticks.
  - Synced seq_state==on → RUNNING.
  - Shutdown code or timer==START_TIMEOUT_TICKS → FAIL.
  - power_request=0 → STOP.
- RUNNING(3): seq_enable=1, dsp_running=1.
  - Timer reaching STABLE_TICKS clears retry_count once.
  - seq_state≠on → FAIL.
  - power_request=0 → STOP.
  - Priority: FAIL over STOP.
- FAIL: single-cycle decision, not a visible state.
  - retry_count==RETRY_MAX → LOCKOUT.
  - Otherwise → BACKOFF, with retry_count incremented in the same cycle.
- BACKOFF(4): seq_enable=0.
  - Once timer ≥ BACKOFF_TICKS<<(retry_count−1) and synced seq_state==off: → START if power_request=1, else → IDLE.
- STOP(5): seq_enable=0.
  - Synced seq_state==off → IDLE.
  - retry_count is unchanged.
- LOCKOUT(6): seq_enable=0, fault=1.
  - fault_clear → IDLE and retry_count=0.
  - fault_clear elsewhere is ignored.
- Code 7: illegal. Recovers to INIT next cycle, seq_enable=0.
- Timer: 16-bit tick counter. Zeroed on every state change. Saturates at 16'hFFFF. No wrap.
- Backoff shift is computed at 16 bits and saturates at 16'hFFFF.

## Timing
- Reset values: seq_enable=0, dsp_running=0, fault=0, retry_count=0, sup_state=0 (INIT), prescaler=0, timer=0, synchroniser=0.
- Tick: a one-cycle pulse when the prescaler hits TICK_DIV−1. The prescaler wraps to 0. The first tick arrives TICK_DIV cycles after reset release.
- seq_state → decision latency: 2 cycles (synchroniser) + 1 cycle (registered state).
- All outputs are registered and decoded from the state register. They change on the cycle after the transition decision.
- Tick-gated transitions (timeouts) are evaluated only on tick cycles. Code-driven transitions are evaluated every cycle.
- Reset mid-operation drops seq_enable within the async-reset propagation time. There is no clean-shutdown guarantee; the sequencer handles its own shutdown on enable loss.

## Configuration
- C66X_SUPERVISOR_AUTO_RETRY_EN defined: retry/backoff behaviour as above.
- Not defined: every FAIL goes directly to LOCKOUT. BACKOFF is unreachable and retry_count stays 0. STABLE_TICKS logic is removed.

## Structure
- Package c66x_power_pkg holds:
  - sequencer state code constants (off, on, shutdown range bounds);
  - supervisor state encodings INIT…LOCKOUT;
  - a shared 16-bit tick-timer width constant.
- One sub-module: c66x_tick_gen (prescaler producing the one-cycle tick, parameter TICK_DIV). It is reusable by the sequencer refactor.

## Test plan
Bench parameters: TICK_DIV=4, STARTUP_TICKS=5, START_TIMEOUT_TICKS=20, BACKOFF_TICKS=8, RETRY_MAX=2, STABLE_TICKS=50.
- Reset held, then released with power_request=1 → seq_enable stays 0 for 20 cycles, then rises. Drive seq_state 1→9 → dsp_running=1 three cycles later.
- In RUNNING, force seq_state=4'hA → seq_enable=0, retry_count=1, sup_state=4. Return seq_state=0 → seq_enable re-rises after 8 ticks (32 cycles).
- Hold seq_state=1 in START → FAIL after 20 ticks. Repeat three times → fault=1, sup_state=6, retry_count=2. fault_clear pulse → sup_state=1, retry_count=0.
- Reach RUNNING with retry_count=2 and hold seq_state=9 for 50 ticks → retry_count=0.
- power_request drops in RUNNING → seq_enable=0, sup_state=5, retry_count unchanged. seq_state=0 → IDLE.
- Assert reset in RUNNING → all outputs reach reset values without a clock edge.
- Build without the macro: first failure → fault=1 directly.

Source files
------------

// File: rtl/c66x_power_pkg.sv
// Shared constants and types for the C66x power supervisor and its sequencer-side helpers.
// Sequencer state codes, supervisor state encodings, tick-timer width, backoff helper.
package c66x_power_pkg;

    localparam int TIMER_W = 16;

    localparam logic [3:0] SEQ_OFF     = 4'h0;
    localparam logic [3:0] SEQ_ON      = 4'h9;
    localparam logic [3:0] SEQ_SHDN_LO = 4'hA;
    localparam logic [3:0] SEQ_SHDN_HI = 4'hE;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_START   = 3'd2,
        ST_RUNNING = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_STOP    = 3'd5,
        ST_LOCKOUT = 3'd6
    } sup_state_e;

    function automatic logic is_shutdown(input logic [3:0] code);
        is_shutdown = (code >= SEQ_SHDN_LO) && (code <= SEQ_SHDN_HI);
    endfunction

    // base << shamt computed wide enough to see overflow, then clamped to the timer range
    function automatic logic [TIMER_W-1:0] backoff_limit(input logic [TIMER_W-1:0] base,
                                                         input logic [1:0]         shamt);
        logic [TIMER_W+2:0] wide;
        wide = {3'b000, base} << shamt;
        backoff_limit = (wide[TIMER_W+2:TIMER_W] != 3'b000) ? '1 : wide[TIMER_W-1:0];
    endfunction

endpackage

// File: rtl/c66x_tick_gen.sv
// Prescaler emitting a one-cycle tick every TICK_DIV clocks; first tick TICK_DIV cycles after reset.
// Free-running, no backpressure; tick is a decode of the prescaler register.
module c66x_tick_gen #(
    parameter int TICK_DIV = 500
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler_q;
    logic [PW-1:0] prescaler_d;

    assign tick_o      = (prescaler_q == LAST);
    assign prescaler_d = tick_o ? '0 : prescaler_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_d;
        end
    end

endmodule

// File: rtl/c66x_power_supervisor.sv
// Supervises the C66x sequencer enable: startup hold-off, start/run watch, retry backoff, fault lockout.
// seq_state->output latency 3 cycles; outputs registered; retry feature enabled by C66X_SUPERVISOR_AUTO_RETRY_EN.
module c66x_power_supervisor
    import c66x_power_pkg::*;
#(
    parameter int TICK_DIV            = 500,
    parameter int STARTUP_TICKS       = 100,
    parameter int START_TIMEOUT_TICKS = 2000,
    parameter int BACKOFF_TICKS       = 250,
    parameter int RETRY_MAX           = 3,
    parameter int STABLE_TICKS        = 10000
) (
    input  logic       sysclk,
    input  logic       sysreset_INV,
    input  logic       power_request,
    input  logic       fault_clear,
    input  logic [3:0] seq_state,
    output logic       seq_enable,
    output logic       dsp_running,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [2:0] sup_state
);

`ifdef C66X_SUPERVISOR_AUTO_RETRY_EN
    localparam bit AUTO_RETRY = 1'b1;
`else
    localparam bit AUTO_RETRY = 1'b0;
`endif

    // Timeouts fire on the tick that brings the count to N, hence the N-1 compare values.
    localparam logic [TIMER_W-1:0] STARTUP_LAST = TIMER_W'(STARTUP_TICKS - 1);
    localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT_TICKS - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_TICKS - 1);
    localparam logic [TIMER_W-1:0] BACKOFF_BASE = TIMER_W'(BACKOFF_TICKS);
    localparam logic [1:0]         RETRY_LIM    = 2'(RETRY_MAX);

    logic               tick;
    logic [3:0]         seq_sync1_q;
    logic [3:0]         seq_sync2_q;
    sup_state_e         state_q;
    sup_state_e         state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic [1:0]         retry_q;
    logic [1:0]         retry_d;
    logic               fail;
    logic               seq_enable_q;
    logic               dsp_running_q;
    logic               fault_q;

    c66x_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_i (sysclk),
        .rst_ni(sysreset_INV),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail    = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (tick && timer_q == STARTUP_LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (power_request && seq_sync2_q == SEQ_OFF) state_d = ST_START;
            end
            ST_START: begin
                if (seq_sync2_q == SEQ_ON) begin
                    state_d = ST_RUNNING;
                end else if (is_shutdown(seq_sync2_q) || (tick && timer_q == START_LAST)) begin
                    fail = 1'b1;
                end else if (!power_request) begin
                    state_d = ST_STOP;
                end
            end
            ST_RUNNING: begin
                if (AUTO_RETRY && tick && timer_q == STABLE_LAST) retry_d = '0;
                if (seq_sync2_q != SEQ_ON) begin
                    fail = 1'b1;
                end else if (!power_request) begin
                    state_d = ST_STOP;
                end
            end
            ST_BACKOFF: begin
                if (timer_q >= backoff_limit(BACKOFF_BASE, retry_q - 2'd1) &&
                    seq_sync2_q == SEQ_OFF) begin
                    state_d = power_request ? ST_START : ST_IDLE;
                end
            end
            ST_STOP: begin
                if (seq_sync2_q == SEQ_OFF) state_d = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (fault_clear) begin
                    state_d = ST_IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // FAIL is a same-cycle decision; it overrides any stable-run clear in that cycle.
        if (fail) begin
            if (!AUTO_RETRY || retry_q == RETRY_LIM) begin
                state_d = ST_LOCKOUT;
                retry_d = retry_q;
            end else begin
                state_d = ST_BACKOFF;
                retry_d = retry_q + 2'd1;
            end
        end

        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_INV) begin
        if (!sysreset_INV) begin
            seq_sync1_q   <= SEQ_OFF;
            seq_sync2_q   <= SEQ_OFF;
            state_q       <= ST_INIT;
            timer_q       <= '0;
            retry_q       <= '0;
            seq_enable_q  <= 1'b0;
            dsp_running_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            seq_sync1_q   <= seq_state;
            seq_sync2_q   <= seq_sync1_q;
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            seq_enable_q  <= (state_d == ST_START) || (state_d == ST_RUNNING);
            dsp_running_q <= (state_d == ST_RUNNING);
            fault_q       <= (state_d == ST_LOCKOUT);
        end
    end

    assign seq_enable  = seq_enable_q;
    assign dsp_running = dsp_running_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign sup_state   = state_q;

endmodule

// File: tb/tb_c66x_power_supervisor.sv
// Bench for c66x_power_supervisor: directed vector table, hand-written lockout/reset sequences,
// and randomized stimulus checked every cycle against a tick-counting reference model.
module tb_c66x_power_supervisor;

    localparam int TICK_DIV            = 4;
    localparam int STARTUP_TICKS       = 5;
    localparam int START_TIMEOUT_TICKS = 20;
    localparam int BACKOFF_TICKS       = 8;
    localparam int RETRY_MAX           = 2;
    localparam int STABLE_TICKS        = 50;

`ifdef C66X_SUPERVISOR_AUTO_RETRY_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       sysclk;
    logic       sysreset_INV;
    logic       power_request;
    logic       fault_clear;
    logic [3:0] seq_state;
    logic       seq_enable;
    logic       dsp_running;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] sup_state;

    c66x_power_supervisor #(
        .TICK_DIV           (TICK_DIV),
        .STARTUP_TICKS      (STARTUP_TICKS),
        .START_TIMEOUT_TICKS(START_TIMEOUT_TICKS),
        .BACKOFF_TICKS      (BACKOFF_TICKS),
        .RETRY_MAX          (RETRY_MAX),
        .STABLE_TICKS       (STABLE_TICKS)
    ) dut (
        .sysclk       (sysclk),
        .sysreset_INV (sysreset_INV),
        .power_request(power_request),
        .fault_clear  (fault_clear),
        .seq_state    (seq_state),
        .seq_enable   (seq_enable),
        .dsp_running  (dsp_running),
        .fault        (fault),
        .retry_count  (retry_count),
        .sup_state    (sup_state)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: supervisor mode numbers as in the state list, elapsed ticks as an integer.
    int         m_mode;
    int         m_retry;
    int         m_ticks;
    int         m_cyc;
    logic [3:0] m_pipe[$];

    typedef struct {
        logic       pr;
        logic       fc;
        logic [3:0] ss;
        int         cycles;
        logic       en;
        logic       run;
        logic       flt;
        logic [1:0] rc;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    function automatic logic [7:0] dut_vec();
        return {seq_enable, dsp_running, fault, retry_count, sup_state};
    endfunction

    function automatic logic [7:0] model_vec();
        logic en, run, flt;
        en  = (m_mode == 2) || (m_mode == 3);
        run = (m_mode == 3);
        flt = (m_mode == 6);
        return {en, run, flt, 2'(m_retry), 3'(m_mode)};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_retry = 0;
        m_ticks = 0;
        m_cyc   = 0;
        m_pipe.delete();
        m_pipe.push_back(4'h0);
        m_pipe.push_back(4'h0);
    endtask

    task automatic model_edge();
        logic [3:0] seen;
        bit         tick;
        bit         failed;
        int         nxt;
        int         r0;
        int         lim;
        m_cyc++;
        tick = (m_cyc % TICK_DIV) == 0;
        seen = m_pipe.pop_front();
        m_pipe.push_back(seq_state);
        nxt    = m_mode;
        failed = 0;
        r0     = m_retry;
        case (m_mode)
            0: if (tick && m_ticks + 1 == STARTUP_TICKS) nxt = 1;
            1: if (power_request && seen == 4'h0) nxt = 2;
            2: begin
                if (seen == 4'h9) nxt = 3;
                else if ((seen >= 4'hA && seen <= 4'hE) ||
                         (tick && m_ticks + 1 == START_TIMEOUT_TICKS)) failed = 1;
                else if (!power_request) nxt = 5;
            end
            3: begin
                if (AUTO && tick && m_ticks + 1 == STABLE_TICKS) m_retry = 0;
                if (seen != 4'h9) failed = 1;
                else if (!power_request) nxt = 5;
            end
            4: begin
                lim = BACKOFF_TICKS << (r0 - 1);
                if (lim > 65535) lim = 65535;
                if (m_ticks >= lim && seen == 4'h0) nxt = power_request ? 2 : 1;
            end
            5: if (seen == 4'h0) nxt = 1;
            6: if (fault_clear) begin
                nxt     = 1;
                m_retry = 0;
            end
            default: nxt = 0;
        endcase
        if (failed) begin
            if (!AUTO || r0 == RETRY_MAX) begin
                nxt     = 6;
                m_retry = r0;
            end else begin
                nxt     = 4;
                m_retry = r0 + 1;
            end
        end
        if (nxt != m_mode) m_ticks = 0;
        else if (tick && m_ticks < 65535) m_ticks++;
        m_mode = nxt;
    endtask

    task automatic cycle();
        @(posedge sysclk);
        model_edge();
        #1;
        check($sformatf("model cyc %0d", m_cyc), dut_vec(), model_vec());
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int maxc, input string name);
        int n;
        n = 0;
        while (sup_state !== tgt && n < maxc) begin
            cycle();
            n++;
        end
        check(name, {5'b0, sup_state}, {5'b0, tgt});
    endtask

    task automatic add_row(input logic pr, input logic fc, input logic [3:0] ss, input int cycles,
                           input logic en, input logic run, input logic flt,
                           input logic [1:0] rc, input logic [2:0] st);
        vec_t v;
        v.pr = pr; v.fc = fc; v.ss = ss; v.cycles = cycles;
        v.en = en; v.run = run; v.flt = flt; v.rc = rc; v.st = st;
        tbl.push_back(v);
    endtask

    function automatic logic [3:0] pick_code();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 4'h0;
        if (r < 6) return 4'h9;
        if (r == 6) return 4'($urandom_range(1, 8));
        if (r == 7) return 4'($urandom_range(10, 14));
        return 4'hF;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // pr fc ss cycles | en run flt rc st
        add_row(1, 0, 4'h0, 20,  0, 0, 0, 2'd0, 3'd1);
        add_row(1, 0, 4'h0, 1,   1, 0, 0, 2'd0, 3'd2);
        add_row(1, 0, 4'h1, 3,   1, 0, 0, 2'd0, 3'd2);
        add_row(1, 0, 4'h9, 2,   1, 0, 0, 2'd0, 3'd2);
        add_row(1, 0, 4'h9, 1,   1, 1, 0, 2'd0, 3'd3);
`ifdef C66X_SUPERVISOR_AUTO_RETRY_EN
        add_row(1, 0, 4'hA, 3,   0, 0, 0, 2'd1, 3'd4);
        add_row(1, 0, 4'h0, 30,  0, 0, 0, 2'd1, 3'd4);
        add_row(1, 0, 4'h0, 1,   1, 0, 0, 2'd1, 3'd2);
        add_row(1, 0, 4'h9, 2,   1, 0, 0, 2'd1, 3'd2);
        add_row(1, 0, 4'h9, 1,   1, 1, 0, 2'd1, 3'd3);
        add_row(0, 0, 4'h9, 1,   0, 0, 0, 2'd1, 3'd5);
        add_row(0, 0, 4'h0, 2,   0, 0, 0, 2'd1, 3'd5);
        add_row(0, 0, 4'h0, 1,   0, 0, 0, 2'd1, 3'd1);
        add_row(1, 0, 4'h0, 1,   1, 0, 0, 2'd1, 3'd2);
        add_row(1, 0, 4'h1, 78,  1, 0, 0, 2'd1, 3'd2);
        add_row(1, 0, 4'h1, 1,   0, 0, 0, 2'd2, 3'd4);
        add_row(1, 0, 4'h0, 64,  0, 0, 0, 2'd2, 3'd4);
        add_row(1, 0, 4'h0, 1,   1, 0, 0, 2'd2, 3'd2);
        add_row(1, 0, 4'h9, 2,   1, 0, 0, 2'd2, 3'd2);
        add_row(1, 0, 4'h9, 1,   1, 1, 0, 2'd2, 3'd3);
        add_row(1, 0, 4'h9, 199, 1, 1, 0, 2'd2, 3'd3);
        add_row(1, 0, 4'h9, 1,   1, 1, 0, 2'd0, 3'd3);
        add_row(0, 0, 4'h9, 1,   0, 0, 0, 2'd0, 3'd5);
        add_row(0, 0, 4'h0, 3,   0, 0, 0, 2'd0, 3'd1);
`else
        add_row(1, 0, 4'hA, 3,   0, 0, 1, 2'd0, 3'd6);
        add_row(1, 0, 4'h0, 30,  0, 0, 1, 2'd0, 3'd6);
        add_row(1, 1, 4'h0, 1,   0, 0, 0, 2'd0, 3'd1);
        add_row(1, 0, 4'h0, 1,   1, 0, 0, 2'd0, 3'd2);
        add_row(1, 0, 4'h1, 77,  1, 0, 0, 2'd0, 3'd2);
        add_row(1, 0, 4'h1, 1,   0, 0, 1, 2'd0, 3'd6);
        add_row(1, 1, 4'h0, 1,   0, 0, 0, 2'd0, 3'd1);
`endif

        sysreset_INV  = 1'b0;
        power_request = 1'b1;
        fault_clear   = 1'b0;
        seq_state     = 4'h0;
        repeat (3) @(posedge sysclk);
        #1;
        check("reset values", dut_vec(), 8'h00);
        sysreset_INV = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            power_request = tbl[i].pr;
            fault_clear   = tbl[i].fc;
            seq_state     = tbl[i].ss;
            repeat (tbl[i].cycles) cycle();
            check($sformatf("row %0d", i), dut_vec(),
                  {tbl[i].en, tbl[i].run, tbl[i].flt, tbl[i].rc, tbl[i].st});
        end
        fault_clear = 1'b0;

`ifdef C66X_SUPERVISOR_AUTO_RETRY_EN
        // Three start failures in a row end in lockout with retry_count at its limit.
        power_request = 1'b1;
        seq_state     = 4'h0;
        wait_state(3'd2, 10, "lockout seq start 1");
        seq_state = 4'h1;
        wait_state(3'd4, 120, "lockout seq fail 1");
        check("lockout seq rc 1", {6'b0, retry_count}, 8'd1);
        seq_state = 4'h0;
        wait_state(3'd2, 60, "lockout seq start 2");
        seq_state = 4'h1;
        wait_state(3'd4, 120, "lockout seq fail 2");
        check("lockout seq rc 2", {6'b0, retry_count}, 8'd2);
        seq_state = 4'h0;
        wait_state(3'd2, 100, "lockout seq start 3");
        seq_state = 4'h1;
        wait_state(3'd6, 120, "lockout seq fail 3");
        check("lockout outputs", dut_vec(), {1'b0, 1'b0, 1'b1, 2'd2, 3'd6});
        seq_state   = 4'h0;
        fault_clear = 1'b1;
        cycle();
        fault_clear = 1'b0;
        check("fault_clear exit", dut_vec(), {1'b0, 1'b0, 1'b0, 2'd0, 3'd1});
`endif

        // Reach RUNNING, then drop reset between clock edges.
        power_request = 1'b1;
        fault_clear   = 1'b0;
        seq_state     = 4'h0;
        wait_state(3'd2, 10, "pre-reset start");
        seq_state = 4'h9;
        wait_state(3'd3, 10, "pre-reset running");
        #2;
        sysreset_INV = 1'b0;
        #1;
        check("async reset in running", dut_vec(), 8'h00);
        repeat (2) @(posedge sysclk);
        #1;
        seq_state    = 4'h0;
        sysreset_INV = 1'b1;
        model_reset();

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 8) seq_state = pick_code();
            if ($urandom_range(0, 59) == 0) power_request = ~power_request;
            fault_clear = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
